// File: rtl/fsm_cmd_arbiter.sv
// rtl/fsm_cmd_arbiter.sv - round-robin command arbiter driving a shared 2-bit mode FSM
// Illegal codes force IDLE and latch a sticky error; a watchdog returns idle-stuck states to IDLE.
module fsm_cmd_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 16,
  localparam int CW     = $clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [3*N_REQ-1:0] cmd_i,
  input  logic               err_clr_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic [1:0]         state_o,
  output logic [2:0]         out_o,
  output logic               busy_o,
  output logic               err_o
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MODE1 = 2'd1,
    ST_MODE2 = 2'd2,
    ST_MODE3 = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  wd_q, wd_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic           err_q, err_d;

  logic [2:0]     cmd_arr [N_REQ];
  logic           found;
  logic [PW-1:0]  winner;
  logic [PW-1:0]  cand;
  logic           accept;
  logic [2:0]     win_cmd;
  int             idx;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign cmd_arr[g] = cmd_i[3*g +: 3];
  end

  // Scan from the round-robin pointer, wrapping once around the requesters.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    idx    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = PW'(idx);
      if (!found && req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign accept  = found && !err_q && !rst;
  assign win_cmd = cmd_arr[winner];

  always_comb begin
    gnt_o = '0;
    if (accept) gnt_o[winner] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    if (err_clr_i) err_d = 1'b0;
    if (accept) begin
      wd_d  = '0;
      ptr_d = (winner == PW'(N_REQ - 1)) ? '0 : winner + PW'(1);
      case (win_cmd)
        3'h0:             state_d = ST_IDLE;
        3'h1, 3'h2, 3'h3: state_d = ST_MODE3;
        3'h4:             state_d = ST_MODE2;
        3'h5:             state_d = ST_MODE1;
        default: begin
          // Illegal code: park safely and block further grants until cleared.
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      endcase
    end else if (state_q == ST_IDLE) begin
      wd_d = '0;
    end else if (wd_q == CW'(TIMEOUT - 1)) begin
      state_d = ST_IDLE;
      wd_d    = '0;
    end else begin
      wd_d = wd_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wd_q    <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  assign state_o = state_q;
  assign out_o   = {1'b1, state_q};
  assign busy_o  = (state_q != ST_IDLE);
  assign err_o   = err_q;

endmodule

// File: tb/tb_fsm_cmd_arbiter.sv
// tb/tb_fsm_cmd_arbiter.sv - vector table, corner sequences and random run against a reference model
module tb_fsm_cmd_arbiter;
  localparam int N_REQ   = 2;
  localparam int TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_i;
  logic [5:0]   cmd_i;
  logic         err_clr_i;
  logic [1:0]   gnt_o;
  logic [1:0]   state_o;
  logic [2:0]   out_o;
  logic         busy_o;
  logic         err_o;

  fsm_cmd_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .cmd_i(cmd_i), .err_clr_i(err_clr_i),
    .gnt_o(gnt_o), .state_o(state_o), .out_o(out_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: mode reached by each command code, plus idle-time bookkeeping.
  int m_state, m_ptr, m_idle;
  bit m_err;
  int target [8] = '{0, 3, 3, 3, 2, 1, 0, 0};

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_idle = 0; m_err = 0;
  endtask

  function automatic int m_winner(input logic [1:0] r);
    if (m_err) return -1;
    for (int i = 0; i < N_REQ; i++) begin
      int k = (m_ptr + i) % N_REQ;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [1:0] m_gnt(input logic [1:0] r);
    int w = m_winner(r);
    return (w < 0) ? 2'b00 : 2'(1 << w);
  endfunction

  task automatic model_edge(input logic [1:0] r, input logic [5:0] c, input logic clr);
    int w = m_winner(r);
    if (w >= 0) begin
      int code = int'((c >> (3 * w)) & 6'h7);
      m_state = target[code];
      if (code >= 6) m_err = 1;
      else if (clr) m_err = 0;
      m_idle = 0;
      m_ptr  = (w + 1) % N_REQ;
    end else begin
      if (clr) m_err = 0;
      if (m_state == 0) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_state = 0;
          m_idle  = 0;
        end
      end
    end
  endtask

  // Called one time unit after a rising edge; returns one time unit after the next.
  task automatic drive(input string tag, input logic [1:0] r, input logic [5:0] c,
                       input logic clr, output logic [1:0] g);
    req_i = r; cmd_i = c; err_clr_i = clr;
    #2;
    g = gnt_o;
    chk({tag, ".gnt"}, gnt_o, m_gnt(r));
    @(posedge clk);
    #1;
    model_edge(r, c, clr);
    chk({tag, ".state"}, state_o, m_state);
    chk({tag, ".err"},   err_o,   m_err);
    chk({tag, ".out"},   out_o,   4 + m_state);
    chk({tag, ".busy"},  busy_o,  m_state != 0);
  endtask

  task automatic do_reset(input logic [1:0] r);
    req_i = r; cmd_i = 6'o11; err_clr_i = 1'b0; rst = 1'b1;
    #1;
    chk("rst.gnt",   gnt_o,   0);
    chk("rst.out",   out_o,   3'b100);
    chk("rst.err",   err_o,   0);
    chk("rst.busy",  busy_o,  0);
    chk("rst.state", state_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [1:0] req;
    logic [5:0] cmd;
    logic       clr;
    logic [1:0] gnt;
    logic [1:0] st;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [1:0] g;
    int density;

    rst = 1'b0; req_i = 2'b11; cmd_i = '0; err_clr_i = 1'b0;
    #1;
    model_reset();
    do_reset(2'b11);

    // decode sweep, round-robin, illegal code, simultaneous set/clear
    tbl.push_back('{2'b01, 6'o00, 1'b0, 2'b01, 2'd0, 1'b0});
    tbl.push_back('{2'b01, 6'o01, 1'b0, 2'b01, 2'd3, 1'b0});
    tbl.push_back('{2'b01, 6'o02, 1'b0, 2'b01, 2'd3, 1'b0});
    tbl.push_back('{2'b01, 6'o03, 1'b0, 2'b01, 2'd3, 1'b0});
    tbl.push_back('{2'b01, 6'o04, 1'b0, 2'b01, 2'd2, 1'b0});
    tbl.push_back('{2'b01, 6'o05, 1'b0, 2'b01, 2'd1, 1'b0});
    tbl.push_back('{2'b11, 6'o41, 1'b0, 2'b10, 2'd2, 1'b0});
    tbl.push_back('{2'b11, 6'o41, 1'b0, 2'b01, 2'd3, 1'b0});
    tbl.push_back('{2'b11, 6'o41, 1'b0, 2'b10, 2'd2, 1'b0});
    tbl.push_back('{2'b11, 6'o41, 1'b0, 2'b01, 2'd3, 1'b0});
    tbl.push_back('{2'b01, 6'o07, 1'b0, 2'b01, 2'd0, 1'b1});
    tbl.push_back('{2'b11, 6'o77, 1'b0, 2'b00, 2'd0, 1'b1});
    tbl.push_back('{2'b11, 6'o77, 1'b1, 2'b00, 2'd0, 1'b0});
    tbl.push_back('{2'b11, 6'o50, 1'b0, 2'b10, 2'd1, 1'b0});
    tbl.push_back('{2'b01, 6'o06, 1'b1, 2'b01, 2'd0, 1'b1});
    tbl.push_back('{2'b00, 6'o00, 1'b1, 2'b00, 2'd0, 1'b0});

    foreach (tbl[i]) begin
      drive($sformatf("vec%0d", i), tbl[i].req, tbl[i].cmd, tbl[i].clr, g);
      chk($sformatf("vec%0d.tgnt", i), g, tbl[i].gnt);
      chk($sformatf("vec%0d.tst", i), state_o, tbl[i].st);
      chk($sformatf("vec%0d.terr", i), err_o, tbl[i].err);
    end

    // watchdog expiry, then a command landing on the last allowed cycle
    drive("wd.start", 2'b01, 6'o04, 1'b0, g);
    chk("wd.start.st", state_o, 2);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      drive("wd.hold", 2'b00, 6'o00, 1'b0, g);
      chk("wd.hold.st", state_o, 2);
    end
    drive("wd.expire", 2'b00, 6'o00, 1'b0, g);
    chk("wd.expire.st", state_o, 0);
    chk("wd.expire.busy", busy_o, 0);
    drive("wd.re", 2'b01, 6'o04, 1'b0, g);
    for (int i = 0; i < TIMEOUT - 1; i++) drive("wd.hold2", 2'b00, 6'o00, 1'b0, g);
    drive("wd.late", 2'b01, 6'o04, 1'b0, g);
    chk("wd.late.st", state_o, 2);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      drive("wd.hold3", 2'b00, 6'o00, 1'b0, g);
      chk("wd.hold3.st", state_o, 2);
    end
    drive("wd.expire2", 2'b00, 6'o00, 1'b0, g);
    chk("wd.expire2.st", state_o, 0);

    // reset in the middle of activity with an error latched
    drive("mid.a", 2'b11, 6'o05, 1'b0, g);
    drive("mid.b", 2'b11, 6'o77, 1'b0, g);
    do_reset(2'b11);
    drive("mid.after", 2'b11, 6'o15, 1'b0, g);
    chk("mid.after.gnt0", g, 2'b01);
    chk("mid.after.st", state_o, 1);

    // random traffic with varying request density
    density = 2;
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic [1:0] r;
      if (cyc % 40 == 0) density = $urandom_range(0, 4);
      r = ($urandom_range(0, 3) < density) ? 2'($urandom_range(0, 3)) : 2'b00;
      if ($urandom_range(0, 299) == 0) do_reset(r);
      drive("rnd", r, 6'($urandom), ($urandom_range(0, 7) == 0), g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
